stopwatch_ctrl: RTL and testbench

Mode and counting controller for the lab stopwatch. It consumes the level outputs of the clock divider (countclk 1 Hz, adjclk 2 Hz, blinkclk ~1.5 Hz) and decides which divided clock advances the BCD minute/second counters. Mode is selected from debounced user controls: run, pause and adjust. It drives the four BCD digits and a per-digit blank mask to the seven-segment display mux, which is itself paced by fastclk.

---
 rtl/stopwatch_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Mode and counting controller for the lab stopwatch. Edge-detects the divided
// clock levels, runs the RUN / PAUSED / ADJ mode FSM and keeps the MM:SS time
// as four BCD digits, plus a blink mask for the field being adjusted.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   countclk        1 Hz level, rising edge = one count tick
//   adjclk          2 Hz level, rising edge = one adjust tick
//   blinkclk        blink phase level
//   pause_p         single-cycle pulse, toggles run/pause
//   clr_p           single-cycle pulse, clears the time (state unchanged)
//   adj             level, 1 = adjust mode
//   sel             level, 0 = adjust minutes, 1 = adjust seconds
//   min_tens..sec_ones  BCD digits
//   digit_blank     [3]=min_tens .. [0]=sec_ones, 1 = blank
//   state           00 RUN, 01 PAUSED, 10 ADJ
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       countclk,
    input  logic       adjclk,
    input  logic       blinkclk,
    input  logic       pause_p,
    input  logic       clr_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] digit_blank,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSED = 2'b01,
        ST_ADJ    = 2'b10
    } state_e;

    localparam logic [7:0] MIN_MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0] SEC_MAX_BCD = 8'h59;

    // Two-digit BCD increment. Returns {wrapped, new_value}; the field wraps
    // to 00 when it already equals its maximum.
    function automatic logic [8:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
        logic [8:0] res;
        res = {1'b0, val};
        if (val == max_val) begin
            res = {1'b1, 8'h00};
        end else if (val[3:0] == 4'd9) begin
            res = {1'b0, val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {1'b0, val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    state_e     state_r, state_next_s;
    logic       paused_flag_r, paused_flag_next_s;
    logic       count_q, adj_q, blink_q;
    logic       count_arm_r, adj_arm_r;
    logic [7:0] min_r, sec_r, min_next_s, sec_next_s;
    logic [3:0] blank_r, blank_next_s;
    logic [8:0] sec_inc_s, min_inc_s;
    logic       count_tick_s, adj_tick_s;

    // A tick needs the level to have been seen low since reset, so a level
    // already high at reset release does not count as an edge.
    assign count_tick_s = countclk & ~count_q & count_arm_r;
    assign adj_tick_s   = adjclk & ~adj_q & adj_arm_r;

    assign sec_inc_s = bcd_inc(sec_r, SEC_MAX_BCD);
    assign min_inc_s = bcd_inc(min_r, MIN_MAX_BCD);

    // Edge-detect history and arming flags for the divider levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 1'b0;
            adj_q       <= 1'b0;
            blink_q     <= 1'b0;
            count_arm_r <= 1'b0;
            adj_arm_r   <= 1'b0;
        end else begin
            count_q     <= countclk;
            adj_q       <= adjclk;
            blink_q     <= blinkclk;
            count_arm_r <= count_arm_r | ~countclk;
            adj_arm_r   <= adj_arm_r | ~adjclk;
        end
    end

    // Mode FSM next-state; adj wins over pause_p, pause_p ignored in ADJ.
    always_comb begin
        state_next_s       = state_r;
        paused_flag_next_s = paused_flag_r;
        case (state_r)
            ST_RUN: begin
                if (adj) begin
                    state_next_s       = ST_ADJ;
                    paused_flag_next_s = 1'b0;
                end else if (pause_p) begin
                    state_next_s = ST_PAUSED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (adj) begin
                    state_next_s       = ST_ADJ;
                    paused_flag_next_s = 1'b1;
                end else if (pause_p) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSED;
                end
            end
            ST_ADJ: begin
                if (!adj) begin
                    state_next_s = paused_flag_r ? ST_PAUSED : ST_RUN;
                end else begin
                    state_next_s = ST_ADJ;
                end
            end
            default: begin
                state_next_s       = ST_RUN;
                paused_flag_next_s = 1'b0;
            end
        endcase
    end

    // Digit update; acts on the pre-transition state, clear beats any tick.
    always_comb begin
        min_next_s = min_r;
        sec_next_s = sec_r;
        if (clr_p) begin
            min_next_s = 8'h00;
            sec_next_s = 8'h00;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (count_tick_s) begin
                        sec_next_s = sec_inc_s[7:0];
                        if (sec_inc_s[8]) begin
                            min_next_s = min_inc_s[7:0];
                        end else begin
                            min_next_s = min_r;
                        end
                    end else begin
                        sec_next_s = sec_r;
                    end
                end
                ST_ADJ: begin
                    if (adj_tick_s) begin
                        if (sel) begin
                            sec_next_s = sec_inc_s[7:0];
                        end else begin
                            min_next_s = min_inc_s[7:0];
                        end
                    end else begin
                        sec_next_s = sec_r;
                    end
                end
                default: begin
                    min_next_s = min_r;
                    sec_next_s = sec_r;
                end
            endcase
        end
    end

    // Blink mask follows the state being entered, so it drops to 0000 on
    // the same edge the FSM leaves ADJ.
    always_comb begin
        blank_next_s = 4'b0000;
        if ((state_next_s == ST_ADJ) && blink_q) begin
            blank_next_s = sel ? 4'b0011 : 4'b1100;
        end else begin
            blank_next_s = 4'b0000;
        end
    end

    // State, time and mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            paused_flag_r <= 1'b0;
            min_r         <= 8'h00;
            sec_r         <= 8'h00;
            blank_r       <= 4'b0000;
        end else begin
            state_r       <= state_next_s;
            paused_flag_r <= paused_flag_next_s;
            min_r         <= min_next_s;
            sec_r         <= sec_next_s;
            blank_r       <= blank_next_s;
        end
    end

    assign min_tens    = min_r[7:4];
    assign min_ones    = min_r[3:0];
    assign sec_tens    = sec_r[7:4];
    assign sec_ones    = sec_r[3:0];
    assign digit_blank = blank_r;
    assign state       = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl. An integer time/mode model predicts
// {state, digit_blank, digits}; expected vectors are queued when stimulus is
// driven and compared once the DUT has clocked the stimulus in.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int MAX_MIN = 59;

    logic       clk;
    logic       rst_n;
    logic       countclk, adjclk, blinkclk;
    logic       pause_p, clr_p, adj, sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0] digit_blank;
    logic [1:0] state;
    logic [21:0] obs_v;

    stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .countclk   (countclk),
        .adjclk     (adjclk),
        .blinkclk   (blinkclk),
        .pause_p    (pause_p),
        .clr_p      (clr_p),
        .adj        (adj),
        .sel        (sel),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .digit_blank(digit_blank),
        .state      (state)
    );

    assign obs_v = {state, digit_blank, min_tens, min_ones, sec_tens, sec_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: minutes, seconds, mode (0 run, 1 paused, 2 adj), paused-on-entry
    int m = 0, s = 0, st = 0, pflag = 0;

    string       tag_q[$];
    logic [21:0] exp_q[$];

    task automatic check_val(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%b blank=%b %h%h:%h%h, expected st=%b blank=%b %h%h:%h%h",
                     tag, obs[21:20], obs[19:16], obs[15:12], obs[11:8], obs[7:4], obs[3:0],
                     exp[21:20], exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    function automatic logic [21:0] model_vec();
        logic [3:0] b;
        b = 4'b0000;
        if (st == 2 && blinkclk === 1'b1) b = sel ? 4'b0011 : 4'b1100;
        return {2'(st), b, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic sb_push(input string tag);
        tag_q.push_back(tag);
        exp_q.push_back(model_vec());
    endtask

    task automatic sb_pop();
        string       t;
        logic [21:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got no queued expectation, expected one");
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_val(t, obs_v, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_inc();
        s++;
        if (s == 60) begin
            s = 0;
            m = (m + 1) % (MAX_MIN + 1);
        end
    endtask

    task automatic cnt_tick(input string tag);
        countclk = 1'b1;
        if (st == 0) run_inc();
        sb_push(tag);
        step();
        countclk = 1'b0;
        step();
        sb_pop();
    endtask

    task automatic adj_tick(input string tag);
        adjclk = 1'b1;
        if (st == 2) begin
            if (sel) s = (s + 1) % 60;
            else     m = (m + 1) % (MAX_MIN + 1);
        end
        sb_push(tag);
        step();
        adjclk = 1'b0;
        step();
        sb_pop();
    endtask

    task automatic pulse_pause(input string tag);
        pause_p = 1'b1;
        if (st == 0)      st = 1;
        else if (st == 1) st = 0;
        sb_push(tag);
        step();
        pause_p = 1'b0;
        step();
        sb_pop();
    endtask

    task automatic set_adj(input logic v, input string tag);
        adj = v;
        if (v && st != 2) begin
            pflag = (st == 1) ? 1 : 0;
            st    = 2;
        end else if (!v && st == 2) begin
            st = (pflag != 0) ? 1 : 0;
        end
        sb_push(tag);
        step();
        sb_pop();
    endtask

    task automatic set_sel(input logic v);
        sel = v;
        step();
    endtask

    task automatic do_clear(input string tag);
        clr_p = 1'b1;
        m = 0;
        s = 0;
        sb_push(tag);
        step();
        clr_p = 1'b0;
        sb_pop();
    endtask

    task automatic set_blink(input logic v, input string tag);
        blinkclk = v;
        sb_push(tag);
        step();
        step();
        sb_pop();
    endtask

    // Go to a given time through ADJ from RUN and come back to RUN.
    task automatic set_time(input int mm, input int ss);
        do_clear("pre_clr");
        set_adj(1'b1, "st_adj_in");
        set_sel(1'b0);
        for (int i = 0; i < mm; i++) adj_tick("st_min");
        set_sel(1'b1);
        for (int i = 0; i < ss; i++) adj_tick("st_sec");
        set_adj(1'b0, "st_adj_out");
    endtask

    initial begin
        rst_n = 1'b0; countclk = 1'b1; adjclk = 1'b0; blinkclk = 1'b0;
        pause_p = 1'b0; clr_p = 1'b0; adj = 1'b0; sel = 1'b0;

        // Reset, with countclk held high through and after release
        repeat (3) step();
        sb_push("rst_hold"); sb_pop();
        rst_n = 1'b1;
        repeat (3) step();
        sb_push("rst_hi_no_tick"); sb_pop();
        countclk = 1'b0;
        step();

        // RUN carries: 60 ticks -> 01:00
        for (int i = 0; i < 60; i++) cnt_tick("run_cnt");
        adj_tick("adj_in_run");

        // Pause
        do_clear("clr0");
        for (int i = 0; i < 7; i++) cnt_tick("to_07");
        pulse_pause("pause_on");
        for (int i = 0; i < 5; i++) cnt_tick("paused_hold");
        adj_tick("paused_adj");
        pulse_pause("pause_off");
        cnt_tick("after_pause");

        // Adjust without carry
        do_clear("clr1");
        for (int i = 0; i < 58; i++) cnt_tick("to_58");
        set_sel(1'b1);
        set_adj(1'b1, "adj_on");
        for (int i = 0; i < 3; i++) adj_tick("adj_sec");
        for (int i = 0; i < 4; i++) cnt_tick("adj_cnt_ign");
        set_sel(1'b0);
        for (int i = 0; i < 2; i++) adj_tick("adj_min");
        set_adj(1'b0, "adj_off_run");

        // MAX_MIN:59 -> 00:00
        set_time(MAX_MIN, 59);
        cnt_tick("full_wrap");

        // Blink mask
        set_sel(1'b0);
        set_adj(1'b1, "blk_adj_in");
        set_blink(1'b1, "blk_min_hi");
        set_blink(1'b0, "blk_min_lo");
        set_blink(1'b1, "blk_min_hi2");
        set_sel(1'b1);
        set_blink(1'b1, "blk_sec_hi");
        set_adj(1'b0, "blk_exit");
        set_blink(1'b0, "blk_run_lo");
        pulse_pause("p_for_adj");
        set_adj(1'b1, "adj_from_p");
        pulse_pause("pause_in_adj");
        set_adj(1'b0, "back_to_p");
        pulse_pause("p_resume");

        // Clear beats a count tick in the same cycle
        set_time(12, 34);
        countclk = 1'b1;
        clr_p    = 1'b1;
        m = 0; s = 0;
        sb_push("clr_prio");
        step();
        clr_p    = 1'b0;
        countclk = 1'b0;
        step();
        sb_pop();

        // Asynchronous reset mid-count at 03:21
        set_time(3, 21);
        countclk = 1'b1;
        rst_n    = 1'b0;
        #2;
        m = 0; s = 0; st = 0; pflag = 0;
        sb_push("rst_async"); sb_pop();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        sb_push("rst2_no_tick"); sb_pop();
        countclk = 1'b0;
        step();
        cnt_tick("rst2_first");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
